// File: rtl/shift_ex_stage.sv
// Execute-stage shift unit: SLL/SRL/SRA over a two-stage valid/ready pipeline
// with flush, illegal-op tagging and a retired-operation counter.
module shift_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;
  localparam int unsigned RDW  = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ILL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [XLEN-1:0] a;
    logic [SHW-1:0]  sh;
    logic [RDW-1:0]  rd;
  } s1_op_t;

  logic            s1_valid;
  s1_op_t          s1_q;
  logic            s2_load;
  logic            accept;
  logic            retire;
  logic [XLEN-1:0] s1_result;
  logic            s1_err;
  logic            unused_b_hi;

  // Only the low five bits of the shift source matter on RV32.
  assign unused_b_hi = ^in_b[31:SHW];

  // Handshake glue: S2 refills when empty or draining; S1 refills when empty or moving on.
  always_comb begin
    s2_load  = s1_valid & (~out_valid | out_ready);
    in_ready = ~s1_valid | s2_load;
    accept   = in_valid & in_ready;
    retire   = out_valid & out_ready;
  end

  // Shift datapath evaluated on the S1 operands.
  always_comb begin
    s1_result = '0;
    s1_err    = 1'b0;
    case (s1_q.op)
      OP_SLL:  s1_result = s1_q.a << s1_q.sh;
      OP_SRL:  s1_result = s1_q.a >> s1_q.sh;
      OP_SRA:  s1_result = XLEN'($signed(s1_q.a) >>> s1_q.sh);
      default: s1_err    = 1'b1;
    endcase
  end

  // S1 operand capture; payload needs no reset since s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q.op <= op_e'(in_op);
      s1_q.a  <= in_a;
      s1_q.sh <= in_b[SHW-1:0];
      s1_q.rd <= in_rd;
    end
  end

  // Valid bits, S2 result register and retire counter; flush kills both stages
  // but a handshake completing on the same edge still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
      out_count  <= '0;
    end else begin
      if (retire) begin
        out_count <= out_count + CNT_W'(1);
      end
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        s1_valid  <= accept | (s1_valid & ~s2_load);
        out_valid <= s2_load | (out_valid & ~out_ready);
      end
      if (s2_load) begin
        out_result <= s1_result;
        out_rd     <= s1_q.rd;
        out_err    <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed self-checking bench for shift_ex_stage (counter width 4 to exercise wrap).
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_err;
  logic [3:0]  out_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_count;

  shift_ex_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_err(out_err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    exp_count = 4'd0;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] as  [3] = '{32'h00000001, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [3] = '{32'd31, 32'd4, 32'd4};
    logic [31:0] ex  [3] = '{32'h80000000, 32'h08000000, 32'hF8000000};
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        drive(ops[c], as[c], bs[c], 5'(c + 1));
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d got=%0b exp=1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 3) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid c=%0d got=%0b exp=1", c, out_valid); end
        checks++; if (out_result !== ex[c-1]) begin errors++; $display("FAIL b2b_result c=%0d got=%h exp=%h", c, out_result, ex[c-1]); end
        checks++; if (out_rd !== 5'(c)) begin errors++; $display("FAIL b2b_rd c=%0d got=%0d exp=%0d", c, out_rd, c); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d got=%0b exp=0", c, out_valid); end
      end
    end
    exp_count = exp_count + 4'd3;
    checks++; if (out_count !== exp_count) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", out_count, exp_count); end
  endtask

  task automatic test_masking();
    logic [1:0]  ops [3] = '{2'b00, 2'b11, 2'b01};
    logic [31:0] as  [3] = '{32'h00000001, 32'h7FFFFFF0, 32'h12345678};
    logic [31:0] bs  [3] = '{32'h00000025, 32'hFFFFFFE4, 32'h00000000};
    logic [31:0] ex  [3] = '{32'h00000020, 32'h07FFFFFF, 32'h12345678};
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(ops[c], as[c], bs[c], 5'(c + 10));
      else in_valid = 1'b0;
      step();
      if (c >= 1 && c <= 3) begin
        checks++; if (out_result !== ex[c-1]) begin errors++; $display("FAIL mask_result c=%0d got=%h exp=%h", c, out_result, ex[c-1]); end
        checks++; if (out_rd !== 5'(c + 9)) begin errors++; $display("FAIL mask_rd c=%0d got=%0d exp=%0d", c, out_rd, c + 9); end
      end
    end
    exp_count = exp_count + 4'd3;
    checks++; if (out_count !== exp_count) begin errors++; $display("FAIL mask_count got=%0d exp=%0d", out_count, exp_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(2'b00, 32'h00000003, 32'd1, 5'd3);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got=%0b exp=1", in_ready); end
    step();
    drive(2'b01, 32'h00000100, 32'd4, 5'd4);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%0b exp=1", in_ready); end
    step();
    drive(2'b11, 32'hFFFFFF00, 32'd8, 5'd5);
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready k=%0d got=%0b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h6 || out_rd !== 5'd3) begin
        errors++; $display("FAIL bp_stall_hold k=%0d got=%0b/%h/%0d exp=1/00000006/3", k, out_valid, out_result, out_rd); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h10 || out_rd !== 5'd4) begin
      errors++; $display("FAIL bp_second got=%0b/%h/%0d exp=1/00000010/4", out_valid, out_result, out_rd); end
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFFFFFF || out_rd !== 5'd5) begin
      errors++; $display("FAIL bp_third got=%0b/%h/%0d exp=1/ffffffff/5", out_valid, out_result, out_rd); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
    exp_count = exp_count + 4'd3;
    checks++; if (out_count !== exp_count) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", out_count, exp_count); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(2'b10, 32'hFFFFFFFF, 32'd3, 5'd7);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_err !== 1'b1 || out_rd !== 5'd7) begin
      errors++; $display("FAIL illegal_out got=%0b/%h/%0b/%0d exp=1/00000000/1/7", out_valid, out_result, out_err, out_rd); end
    step();
    exp_count = exp_count + 4'd1;
    checks++; if (out_count !== exp_count) begin errors++; $display("FAIL illegal_count got=%0d exp=%0d", out_count, exp_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(2'b00, 32'h1, 32'd1, 5'd20);
    step();
    drive(2'b00, 32'h1, 32'd2, 5'd21);
    step();
    drive(2'b00, 32'h1, 32'd3, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost k=%0d got=%0b exp=0", k, out_valid); end
    end
    checks++; if (out_count !== exp_count) begin errors++; $display("FAIL flush_count got=%0d exp=%0d", out_count, exp_count); end
  endtask

  task automatic test_reset_wrap();
    out_ready = 1'b0;
    drive(2'b01, 32'hF0, 32'd4, 5'd9);
    step();
    drive(2'b01, 32'hF0, 32'd2, 5'd10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_rd !== 5'd0 || out_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs got=%0b/%h/%0d/%0b exp=0/00000000/0/0", out_valid, out_result, out_rd, out_err); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(2'b00, 32'(i), 32'd0, 5'(i));
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", out_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_masking();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
- Execute-stage shift unit of the 32-bit RISC-V ALU.
- Sits between the decode/issue stage and the writeback stage.
- Accepts decoded shift micro-ops over a valid/ready handshake and computes SLL/SRL/SRA in a 2-stage pipeline.
- Delivers results with destination register tag under downstream backpressure, and keeps a retired-op counter.

Parameters:
CNT_W, 16, width of the retired-operation counter out_count.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  issue stage presents a shift micro-op
in_ready  output  1  stage can accept a micro-op this cycle
in_op  input  2  00=SLL, 01=SRL, 11=SRA, 10=illegal
in_a  input  32  operand rs1
in_b  input  32  shift source (rs2 or immediate); only in_b[4:0] used
in_rd  input  5  destination register tag
flush  input  1  pipeline kill (branch mispredict/trap)
out_valid  output  1  result available
out_ready  input  1  writeback accepts result
out_result  output  32  shift result
out_rd  output  5  destination tag of out_result
out_err  output  1  result came from illegal op
out_count  output  CNT_W  number of results retired (out_valid & out_ready)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: both stage valid bits 0; out_valid=0, out_result=0, out_rd=0, out_err=0, out_count=0. in_ready=1 in the first cycle after reset.
- Accept: a micro-op is accepted on a rising edge where in_valid & in_ready.
- Stage S1 (operand register) captures in_op, in_a, in_b[4:0], in_rd.
- Stage S2 (result register) holds the computed result and drives out_*.
- S2 advance: S2 loads from S1 when s1_valid & (!s2_valid | out_ready).
- in_ready = !s1_valid | s2_load (S1 is empty or draining this cycle). It is purely combinational from the state and out_ready; it does not depend on in_valid.
- Latency: a result appears on out_valid exactly 2 cycles after acceptance when unstalled.
- Throughput: 1 op/cycle when out_ready is held high.
- Order: results leave strictly in acceptance order, with no drops and no duplicates.
- Stall: while out_valid & !out_ready, out_result, out_rd and out_err hold stable. S1 holds its op. in_ready=0 once S1 is occupied.
- Arithmetic, with s = in_b[4:0]:
  - SLL: a << s, zero fill.
  - SRL: a >> s, zero fill.
  - SRA: a >> s, filling with a[31].
  - s=0 returns a unchanged for all legal ops.
- Illegal op (10): out_result=0, out_err=1. It still flows through the pipeline and counts as retired.
- Flush: when flush=1 at a rising edge, both valid bits clear that edge, regardless of stall.
  - A simultaneous in_valid on that edge is discarded.
  - out_valid=0 and in_ready=1 from the next cycle.
  - An output handshake (out_valid & out_ready) on the flush edge still counts as retired.
- Reset mid-operation: all in-flight ops are dropped and the counter clears. rst has priority over flush.
- Counter: out_count increments by 1 on each out_valid & out_ready edge. It wraps from 2^CNT_W-1 to 0. It is not cleared by flush.
- Data hygiene: S1/S2 data registers are not reset-required except the values of outputs listed above. out_result/out_rd/out_err are only meaningful while out_valid=1.

Test Plan:
1. Back-to-back ops, out_ready=1:
   - Issue SLL a=0x00000001 b=31, then SRL a=0x80000000 b=4, then SRA a=0x80000000 b=4.
   - Expect out_result 0x80000000, 0x08000000, 0xF8000000 on 3 consecutive cycles, starting 2 cycles after the first accept.
   - Expect out_count=3.
2. Shift-amount masking:
   - SLL a=0x00000001 b=0x00000025 -> 0x00000020.
   - SRA a=0x7FFFFFF0 b=0xFFFFFFE4 -> 0x07FFFFFF.
   - SRL a=0x12345678 b=0 -> 0x12345678.
3. Backpressure:
   - Hold out_ready=0 and offer 3 ops.
   - Expect exactly 2 accepted and in_ready=0 with the third op pending; out_result stable throughout.
   - Raise out_ready: all 3 retire in order on consecutive cycles.
4. Illegal op: in_op=10, a=0xFFFFFFFF, b=3 -> out_result=0x00000000, out_err=1, out_count increments.
5. Flush during stall:
   - With 2 ops in flight and out_ready=0, pulse flush together with in_valid=1.
   - Next cycle: out_valid=0, in_ready=1, no result from any of the 3 ops ever appears, out_count unchanged.
6. Reset and counter wrap:
   - Assert rst with ops in flight: next cycle all outputs at their reset values.
   - With CNT_W=4, retire 17 ops: out_count=1.
